mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported byte-addressed RAM in the datapath.
- Requester 0 (C) is the control-unit memory port (MFA/RW/type/MFC handshake). Requester 1 (L) is a program loader / debug port that fills or inspects RAM at run time.
- The arbiter latches the granted request, drives the RAM handshake, and routes MFC and read data back to the granted requester.
- It also adds alignment checking and a watchdog timeout.

Parameters:
- AW, 8, address width (byte address).
- DW, 32, data width.
- TIMEOUT, 16, max cycles in ACCESS waiting for RAM MFC; legal range is 2 or more.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- c_MFA  in  1  C request; held until c_MFC is seen.
- c_RW  in  1  C direction; 0 = read, 1 = write.
- c_TYPE  in  2  C size; 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- c_ADDR  in  AW  C byte address.
- c_DIN  in  DW  C write data.
- c_DOUT  out  DW  C read data.
- c_MFC  out  1  C completion.
- c_ERR  out  1  C error; valid while c_MFC = 1.
- l_MFA, l_RW, l_TYPE, l_ADDR, l_DIN, l_DOUT, l_MFC, l_ERR: same as the c_ ports, for requester L.
- m_MFA  out  1  RAM function activate.
- m_RW  out  1  RAM direction.
- m_TYPE  out  2  RAM size.
- m_ADDR  out  AW  RAM address.
- m_DOUT  out  DW  RAM write data.
- m_DIN  in  DW  RAM read data.
- m_MFC  in  1  RAM function complete.
- busy  out  1  1 in ACCESS or RELEASE.
- grant  out  1  owner of the current or last transfer; 0 = C, 1 = L.

Behaviour:

Reset:
- All outputs go to 0 immediately, with no clock needed.
- State = IDLE, last_grant = 1 (so C wins the first tie), watchdog = 0.

FSM states: IDLE, ACCESS, RELEASE.

IDLE:
- At a rising edge, if any MFA is high, pick the winner:
  - One requester high: that requester wins.
  - Both high: round-robin, the winner is ~last_grant.
- Latch the winner's RW, TYPE, ADDR and DIN into internal registers. Requester input changes after the grant are ignored.
- Alignment check at the same edge:
  - Misaligned means TYPE = 10 with ADDR[1:0] != 0, TYPE = 01 with ADDR[0] = 1, or TYPE = 11.
  - Misaligned: go directly to RELEASE with ERR = 1; the RAM is never activated.
  - Aligned: go to ACCESS.

ACCESS:
- m_MFA = 1; m_RW, m_TYPE, m_ADDR, m_DOUT are driven from the latched registers.
- The watchdog counts edges spent in ACCESS.
- At an edge with m_MFC = 1:
  - If read, capture m_DIN into the winner's DOUT register.
  - Go to RELEASE with ERR = 0.
- Else, if the watchdog equals TIMEOUT-1: go to RELEASE with ERR = 1; DOUT is unchanged.
- m_MFC and timeout at the same edge: MFC wins, ERR = 0.
- The winner dropping MFA during ACCESS does not abort the transfer; it completes normally.

RELEASE:
- m_MFA = 0.
- The winner's MFC output = 1 and ERR output = the recorded value. The other port's MFC/ERR = 0.
- Stay until the winner's MFA is sampled low. At that edge: MFC/ERR go to 0, last_grant = winner, go to IDLE.
- So MFC lasts at least one cycle and at least one IDLE cycle separates any two grants.

Timing and data rules:
- Latency, aligned access: request sampled at edge k gives m_MFA high from k+1. RAM MFC sampled at edge j gives requester MFC high from j+1.
- Latency, misaligned access: requester MFC and ERR high from k+1.
- A write leaves that port's DOUT unchanged. DOUT holds the last successful read until overwritten.
- Each port has its own DOUT register.
- m_DOUT and m_ADDR hold their latched values outside ACCESS; they are don't-care for the RAM.
- The request held while waiting is not lost: the losing requester keeps MFA high and is served on the next IDLE.

Decomposition:
- Package mem_pkg holds:
  - size codes SZ_BYTE = 00, SZ_HALF = 01, SZ_WORD = 10;
  - RW codes RD = 0, WR = 1;
  - the FSM state encoding;
  - the alignment-check function.
- One sub-module, mem_watchdog: a counter with clear/enable and an expired output, width $clog2(TIMEOUT).

Test Plan:
1. C word read at 0x08; RAM model asserts MFC after 3 cycles with data 0xE3A01005 → m_MFA high 3 cycles, m_ADDR = 0x08, m_TYPE = 10, m_RW = 0. c_DOUT = 0xE3A01005 and c_MFC rise one cycle after m_MFC. l_MFC stays 0.
2. After reset, C read 0x10 and L write 0x20 with data 0xDEADBEEF, raised in the same cycle → C is served first, then L. m_ADDR sequence is 0x10 then 0x20, m_RW 0 then 1, m_DOUT = 0xDEADBEEF, grant 0 then 1. Both then re-request → C is granted.
3. TIMEOUT = 16 and the RAM never asserts MFC → m_MFA high exactly 16 cycles then low, c_MFC = 1 with c_ERR = 1, c_DOUT unchanged.
4. C word read at 0x06 → m_MFA never asserted; c_MFC = 1 and c_ERR = 1 one cycle after the request; next aligned read works normally.
5. Reset pulsed mid-ACCESS → m_MFA, busy and c_MFC go to 0 without a clock edge. After release, simultaneous C/L requests grant C first.
6. C holds c_MFA for 4 cycles after c_MFC while L requests → c_MFC stays high 4 cycles, m_MFA stays 0 throughout, L is granted only after C drops MFA and one IDLE cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory arbiter.
//   - size codes and direction codes used on both requester and RAM sides
//   - arbiter FSM state encoding
//   - alignment check used when a request is granted
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Reserved size (11) is treated as misaligned so it never reaches the RAM.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lsb);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lsb[0];
      SZ_WORD: bad = (addr_lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts clock edges while enabled and flags when the count
// reaches TIMEOUT-1.
//   CLK      in  clock, rising edge
//   Reset    in  asynchronous active-high reset
//   clear    in  synchronous clear (has priority over enable)
//   enable   in  count one edge
//   expired  out count == TIMEOUT-1
module mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Saturates at TIMEOUT-1; the FSM leaves ACCESS on that edge anyway.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter/sequencer in front of a single-ported
// byte-addressed RAM. Requester C (control unit) and requester L (loader/
// debug) share the RAM through an MFA/MFC handshake. The granted request is
// latched, alignment-checked, sent to the RAM, and completion/data/error are
// routed back to the winner. A watchdog bounds the wait for RAM MFC.
//
// Ports:
//   CLK, Reset                      clock, asynchronous active-high reset
//   c_MFA/RW/TYPE/ADDR/DIN          requester C request
//   c_DOUT/MFC/ERR                  requester C response
//   l_*                             same set for requester L
//   m_MFA/RW/TYPE/ADDR/DOUT         RAM request
//   m_DIN/MFC                       RAM response
//   busy                            1 in ACCESS or RELEASE
//   grant                           owner of current/last transfer (0=C, 1=L)
//
// States:
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no transfer; arbitrate and latch the winner on any MFA
//   ST_ACCESS  | RAM activated, waiting for m_MFC or watchdog expiry
//   ST_RELEASE | winner sees MFC/ERR until it drops its MFA
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          Reset,

  input  logic          c_MFA,
  input  logic          c_RW,
  input  logic [1:0]    c_TYPE,
  input  logic [AW-1:0] c_ADDR,
  input  logic [DW-1:0] c_DIN,
  output logic [DW-1:0] c_DOUT,
  output logic          c_MFC,
  output logic          c_ERR,

  input  logic          l_MFA,
  input  logic          l_RW,
  input  logic [1:0]    l_TYPE,
  input  logic [AW-1:0] l_ADDR,
  input  logic [DW-1:0] l_DIN,
  output logic [DW-1:0] l_DOUT,
  output logic          l_MFC,
  output logic          l_ERR,

  output logic          m_MFA,
  output logic          m_RW,
  output logic [1:0]    m_TYPE,
  output logic [AW-1:0] m_ADDR,
  output logic [DW-1:0] m_DOUT,
  input  logic [DW-1:0] m_DIN,
  input  logic          m_MFC,

  output logic          busy,
  output logic          grant
);

  arb_state_e state, state_nxt;

  logic          owner;       // winner of the current/last grant
  logic          last_grant;  // round-robin history, updated on release
  logic          lat_rw;
  logic [1:0]    lat_type;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_din;
  logic          err_q;
  logic [DW-1:0] c_dout_q;
  logic [DW-1:0] l_dout_q;

  logic          req_any;
  logic          pick_l;
  logic          sel_rw;
  logic [1:0]    sel_type;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;
  logic          sel_misaligned;
  logic          owner_mfa;
  logic          wd_expired;
  logic          in_access;

  // Arbitration: a lone requester wins; on a tie the one that did not own
  // the previous transfer wins.
  assign req_any  = c_MFA | l_MFA;
  assign pick_l   = l_MFA & (~c_MFA | ~last_grant);
  assign sel_rw   = pick_l ? l_RW   : c_RW;
  assign sel_type = pick_l ? l_TYPE : c_TYPE;
  assign sel_addr = pick_l ? l_ADDR : c_ADDR;
  assign sel_din  = pick_l ? l_DIN  : c_DIN;
  assign sel_misaligned = is_misaligned(sel_type, sel_addr[1:0]);

  assign owner_mfa = owner ? l_MFA : c_MFA;
  assign in_access = (state == ST_ACCESS);

  mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK     (CLK),
    .Reset   (Reset),
    .clear   (~in_access),
    .enable  (in_access),
    .expired (wd_expired)
  );

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          state_nxt = sel_misaligned ? ST_RELEASE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (m_MFC || wd_expired) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!owner_mfa) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, error record and per-port read data
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      lat_rw     <= 1'b0;
      lat_type   <= 2'b00;
      lat_addr   <= '0;
      lat_din    <= '0;
      err_q      <= 1'b0;
      c_dout_q   <= '0;
      l_dout_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            owner    <= pick_l;
            lat_rw   <= sel_rw;
            lat_type <= sel_type;
            lat_addr <= sel_addr;
            lat_din  <= sel_din;
            err_q    <= sel_misaligned;
          end
        end
        ST_ACCESS: begin
          // RAM completion beats a coincident watchdog expiry.
          if (m_MFC) begin
            err_q <= 1'b0;
            if (lat_rw == RD) begin
              if (owner) l_dout_q <= m_DIN;
              else       c_dout_q <= m_DIN;
            end
          end else if (wd_expired) begin
            err_q <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!owner_mfa) begin
            last_grant <= owner;
            err_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    m_MFA = 1'b0;
    busy  = 1'b0;
    c_MFC = 1'b0;
    c_ERR = 1'b0;
    l_MFC = 1'b0;
    l_ERR = 1'b0;
    case (state)
      ST_ACCESS: begin
        m_MFA = 1'b1;
        busy  = 1'b1;
      end
      ST_RELEASE: begin
        busy = 1'b1;
        if (owner) begin
          l_MFC = 1'b1;
          l_ERR = err_q;
        end else begin
          c_MFC = 1'b1;
          c_ERR = err_q;
        end
      end
      default: ;
    endcase
  end

  // RAM-side fields simply mirror the latch; the RAM ignores them unless
  // m_MFA is high.
  assign m_RW   = lat_rw;
  assign m_TYPE = lat_type;
  assign m_ADDR = lat_addr;
  assign m_DOUT = lat_din;
  assign c_DOUT = c_dout_q;
  assign l_DOUT = l_dout_q;
  assign grant  = owner;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          c_MFA, c_RW, l_MFA, l_RW;
  logic [1:0]    c_TYPE, l_TYPE;
  logic [AW-1:0] c_ADDR, l_ADDR;
  logic [DW-1:0] c_DIN, l_DIN, c_DOUT, l_DOUT;
  logic          c_MFC, c_ERR, l_MFC, l_ERR;
  logic          m_MFA, m_RW, m_MFC;
  logic [1:0]    m_TYPE;
  logic [AW-1:0] m_ADDR;
  logic [DW-1:0] m_DOUT, m_DIN;
  logic          busy, grant;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset),
    .c_MFA(c_MFA), .c_RW(c_RW), .c_TYPE(c_TYPE), .c_ADDR(c_ADDR), .c_DIN(c_DIN),
    .c_DOUT(c_DOUT), .c_MFC(c_MFC), .c_ERR(c_ERR),
    .l_MFA(l_MFA), .l_RW(l_RW), .l_TYPE(l_TYPE), .l_ADDR(l_ADDR), .l_DIN(l_DIN),
    .l_DOUT(l_DOUT), .l_MFC(l_MFC), .l_ERR(l_ERR),
    .m_MFA(m_MFA), .m_RW(m_RW), .m_TYPE(m_TYPE), .m_ADDR(m_ADDR), .m_DOUT(m_DOUT),
    .m_DIN(m_DIN), .m_MFC(m_MFC),
    .busy(busy), .grant(grant)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- RAM stub ----------------
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] exp_mem [256];
  int            ram_delay = 1;
  bit            ram_stall = 0;
  int            ram_cnt = 0;
  int            mfa_cycles = 0;
  logic [AW-1:0] obs_addr;
  logic [1:0]    obs_type;
  logic          obs_rw;
  logic [DW-1:0] obs_dout;
  bit            obs_changed = 0;

  initial begin
    m_MFC = 1'b0;
    m_DIN = '0;
    forever begin
      @(negedge CLK);
      if (m_MFA === 1'b1) mfa_cycles++;
      if (m_MFA === 1'b1 && m_MFC === 1'b0) begin
        ram_cnt++;
        if (ram_cnt == 1) begin
          obs_addr = m_ADDR; obs_type = m_TYPE; obs_rw = m_RW; obs_dout = m_DOUT;
        end else if (m_ADDR !== obs_addr || m_TYPE !== obs_type ||
                     m_RW !== obs_rw || m_DOUT !== obs_dout) begin
          obs_changed = 1;
        end
        if (!ram_stall && ram_cnt == ram_delay) begin
          m_MFC = 1'b1;
          if (m_RW) ram_mem[m_ADDR] = m_DOUT;
          else      m_DIN = ram_mem[m_ADDR];
        end
      end else begin
        m_MFC = 1'b0;
        ram_cnt = 0;
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] exp_dout [2];
  bit            last_grant_m;

  bit            t_en    [2];
  bit            t_rw    [2];
  logic [1:0]    t_type  [2];
  logic [AW-1:0] t_addr  [2];
  logic [DW-1:0] t_din   [2];
  int            t_delay [2];
  bit            t_stall [2];
  int            t_hold  [2];

  function automatic bit model_misaligned(input int size, input int addr);
    if (size == 3) return 1;
    if (size == 2 && (addr % 4) != 0) return 1;
    if (size == 1 && (addr % 2) != 0) return 1;
    return 0;
  endfunction

  task automatic drive_port(input int p, input bit mfa, input bit rw, input logic [1:0] ty,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      c_MFA = mfa; c_RW = rw; c_TYPE = ty; c_ADDR = a; c_DIN = d;
    end else begin
      l_MFA = mfa; l_RW = rw; l_TYPE = ty; l_ADDR = a; l_DIN = d;
    end
  endtask

  function automatic logic port_mfc(input int p);
    return (p == 0) ? c_MFC : l_MFC;
  endfunction
  function automatic logic port_err(input int p);
    return (p == 0) ? c_ERR : l_ERR;
  endfunction
  function automatic logic [DW-1:0] port_dout(input int p);
    return (p == 0) ? c_DOUT : l_DOUT;
  endfunction

  // Raise the enabled requests together, then follow each grant to completion.
  task automatic do_round();
    int order[$];
    int p, waited, lat, exp_cycles, grant_at;
    bit mis, exp_err;
    if (t_en[0] && t_en[1]) begin
      p = last_grant_m ? 0 : 1;
      order.push_back(p);
      order.push_back(1 - p);
    end else if (t_en[0]) order.push_back(0);
    else if (t_en[1]) order.push_back(1);
    else return;

    for (int i = 0; i < order.size(); i++) begin
      p = order[i];
      ram_delay = t_delay[p];
      ram_stall = t_stall[p];
      mfa_cycles = 0;
      obs_changed = 0;
      if (i == 0) begin
        for (int q = 0; q < 2; q++)
          if (t_en[q]) drive_port(q, 1'b1, t_rw[q], t_type[q], t_addr[q], t_din[q]);
      end
      mis = model_misaligned(int'(t_type[p]), int'(t_addr[p]));
      exp_err = mis || t_stall[p];
      if (mis)             exp_cycles = 0;
      else if (t_stall[p]) exp_cycles = TIMEOUT;
      else                 exp_cycles = t_delay[p];
      lat = exp_cycles + 1;
      grant_at = 1;
      waited = 0;
      do begin
        @(negedge CLK);
        waited++;
        // winner's inputs are scrambled after the grant and must be ignored
        if (waited == grant_at && port_mfc(p) !== 1'b1)
          drive_port(p, 1'b1, ~t_rw[p], 2'($urandom), AW'($urandom), DW'($urandom));
      end while (port_mfc(p) !== 1'b1 && waited < 100);
      chk("mfc_latency", waited, lat);

      if (!exp_err && !t_rw[p]) exp_dout[p] = exp_mem[t_addr[p]];
      if (!exp_err &&  t_rw[p]) exp_mem[t_addr[p]] = t_din[p];

      chk("grant", grant, p);
      chk("err", port_err(p), exp_err);
      chk("dout_winner", port_dout(p), exp_dout[p]);
      chk("dout_other", port_dout(1 - p), exp_dout[1 - p]);
      chk("mfc_other", port_mfc(1 - p), 0);
      chk("busy_release", busy, 1);
      chk("ram_mfa_cycles", mfa_cycles, exp_cycles);
      if (!mis) begin
        chk("ram_addr", obs_addr, t_addr[p]);
        chk("ram_type", obs_type, t_type[p]);
        chk("ram_rw", obs_rw, t_rw[p]);
        chk("ram_stable", obs_changed, 0);
        if (t_rw[p]) chk("ram_wdata", obs_dout, t_din[p]);
      end

      for (int h = 0; h < t_hold[p]; h++) begin
        @(negedge CLK);
        chk("mfc_hold", port_mfc(p), 1);
        chk("mfa_hold", m_MFA, 0);
      end
      if (p == 0) c_MFA = 1'b0; else l_MFA = 1'b0;
      last_grant_m = p[0];
      @(negedge CLK);
      chk("mfc_drop", port_mfc(p), 0);
      chk("idle_gap", busy, 0);
    end
  endtask

  task automatic set_req(input int p, input bit en, input bit rw, input logic [1:0] ty,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int dly, input bit stall, input int hold);
    t_en[p] = en; t_rw[p] = rw; t_type[p] = ty; t_addr[p] = a; t_din[p] = d;
    t_delay[p] = dly; t_stall[p] = stall; t_hold[p] = hold;
  endtask

  task automatic model_reset();
    last_grant_m = 1;
    exp_dout[0] = '0;
    exp_dout[1] = '0;
  endtask

  initial begin
    int en;
    Reset = 1'b1;
    drive_port(0, 0, 0, 2'b00, '0, '0);
    drive_port(1, 0, 0, 2'b00, '0, '0);
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = $urandom;
      exp_mem[i] = ram_mem[i];
    end
    ram_mem[8] = 32'hE3A01005;
    exp_mem[8] = 32'hE3A01005;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst_m_mfa", m_MFA, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_mfc", {c_MFC, l_MFC, c_ERR, l_ERR}, 0);
    chk("rst_dout", {c_DOUT, l_DOUT}, 0);
    chk("rst_m_fields", {m_RW, m_TYPE, m_ADDR, m_DOUT}, 0);
    Reset = 1'b0;
    @(negedge CLK);

    // C word read at 0x08, RAM answers after 3 cycles
    set_req(0, 1, 0, 2'b10, 8'h08, '0, 3, 0, 0);
    set_req(1, 0, 0, 2'b00, '0, '0, 1, 0, 0);
    do_round();
    chk("read_0x08", c_DOUT, 32'hE3A01005);

    // fresh reset: simultaneous C read / L write, C first; then re-request
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    model_reset();
    set_req(0, 1, 0, 2'b10, 8'h10, '0, 2, 0, 0);
    set_req(1, 1, 1, 2'b10, 8'h20, 32'hDEADBEEF, 2, 0, 0);
    do_round();
    chk("write_landed", ram_mem[8'h20], 32'hDEADBEEF);
    set_req(0, 1, 0, 2'b10, 8'h20, '0, 1, 0, 0);
    set_req(1, 1, 0, 2'b10, 8'h10, '0, 1, 0, 0);
    do_round();

    // watchdog timeout, and RAM MFC on the very last allowed edge
    set_req(0, 1, 0, 2'b10, 8'h30, '0, 1, 1, 0);
    set_req(1, 0, 0, 2'b00, '0, '0, 1, 0, 0);
    do_round();
    set_req(0, 1, 0, 2'b10, 8'h34, '0, TIMEOUT, 0, 0);
    do_round();

    // misaligned word read, then a normal read
    set_req(0, 1, 0, 2'b10, 8'h06, '0, 1, 0, 0);
    do_round();
    set_req(0, 1, 0, 2'b01, 8'h06, '0, 2, 0, 0);
    do_round();

    // C holds MFA 4 cycles after MFC while L waits
    set_req(0, 1, 0, 2'b00, 8'h41, '0, 2, 0, 4);
    set_req(1, 1, 1, 2'b01, 8'h42, 32'h1234ABCD, 1, 0, 2);
    do_round();

    // reset pulsed mid-ACCESS
    ram_stall = 1;
    mfa_cycles = 0;
    drive_port(0, 1, 0, 2'b10, 8'h44, '0);
    repeat (4) @(negedge CLK);
    chk("pre_rst_mfa", m_MFA, 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_mfa", m_MFA, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_mfc", c_MFC, 0);
    chk("async_rst_dout", c_DOUT, 0);
    drive_port(0, 0, 0, 2'b00, '0, '0);
    model_reset();
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    set_req(0, 1, 1, 2'b10, 8'h48, 32'h0BADF00D, 1, 0, 0);
    set_req(1, 1, 0, 2'b10, 8'h48, '0, 1, 0, 0);
    do_round();

    // randomized rounds
    for (int r = 0; r < 60; r++) begin
      en = $urandom_range(1, 3);
      for (int q = 0; q < 2; q++) begin
        t_en[q]   = en[q];
        t_rw[q]   = 1'($urandom_range(0, 1));
        t_type[q] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        t_addr[q] = AW'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) begin
          if (t_type[q] == 2'b10) t_addr[q] = t_addr[q] & 8'hFC;
          if (t_type[q] == 2'b01) t_addr[q] = t_addr[q] & 8'hFE;
        end
        t_din[q]   = $urandom;
        t_delay[q] = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(1, 4);
        t_stall[q] = ($urandom_range(0, 9) == 0);
        t_hold[q]  = $urandom_range(0, 3);
      end
      do_round();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
